// File: rtl/xor_fold_scheduler.sv
// -----------------------------------------------------------------------------
// xor_fold_scheduler
// Shared serial XOR-fold engine arbitrated between two requesters. One
// requester at a time is granted the single accumulator for a whole frame of
// LEN words; the folded result (XOR of all words) is returned with the tag of
// the requester that produced it. Grants alternate round-robin on ties.
//
// Ports:
//   CLK               clock, all state updates on the rising edge
//   RESET             synchronous, active-high reset
//   I0_valid/I0_data  requester 0 word stream
//   I0_ready          requester 0 word accepted when high together with valid
//   I1_valid/I1_data  requester 1 word stream
//   I1_ready          requester 1 word accepted when high together with valid
//   O_valid/O_data    registered folded result
//   O_tag             registered index of the requester owning O_data
//   O_ready           downstream accepts the result
// -----------------------------------------------------------------------------
module xor_fold_scheduler #(
    parameter int WIDTH = 2,
    parameter int LEN   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I0_valid,
    input  logic [WIDTH-1:0] I0_data,
    output logic             I0_ready,
    input  logic             I1_valid,
    input  logic [WIDTH-1:0] I1_data,
    output logic             I1_ready,
    output logic             O_valid,
    output logic [WIDTH-1:0] O_data,
    output logic             O_tag,
    input  logic             O_ready
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             owner_r;
    logic             last_grant_r;
    logic             o_valid_r;
    logic [WIDTH-1:0] o_data_r;
    logic             o_tag_r;

    logic             grantee_s;
    logic             owner_valid_s;
    logic [WIDTH-1:0] owner_data_s;
    logic [WIDTH-1:0] acc_next_s;

    // Round-robin pick: on a tie the requester that did not win last time
    // is chosen; otherwise the single requester asking is chosen.
    function automatic logic pick_grantee(input logic v0, input logic v1,
                                          input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v0) begin
            g = 1'b0;
        end else begin
            g = 1'b1;
        end
        return g;
    endfunction

    // Select the owner's word stream and form the next accumulator value.
    always_comb begin
        grantee_s = pick_grantee(I0_valid, I1_valid, last_grant_r);
        if (owner_r) begin
            owner_valid_s = I1_valid;
            owner_data_s  = I1_data;
        end else begin
            owner_valid_s = I0_valid;
            owner_data_s  = I0_data;
        end
        acc_next_s = acc_r ^ owner_data_s;
    end

    // Frame sequencing: grant, accumulate LEN words, hold the result until taken.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            acc_r        <= '0;
            cnt_r        <= '0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            o_valid_r    <= 1'b0;
            o_data_r     <= '0;
            o_tag_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Grant cycle consumes no word.
                    if (I0_valid || I1_valid) begin
                        owner_r      <= grantee_s;
                        last_grant_r <= grantee_s;
                        acc_r        <= '0;
                        cnt_r        <= '0;
                        state_r      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (owner_valid_s) begin
                        acc_r <= acc_next_s;
                        if (cnt_r == CNT_LAST) begin
                            // Counter is left at its last value so it never wraps.
                            state_r   <= ST_DONE;
                            o_valid_r <= 1'b1;
                            o_data_r  <= acc_next_s;
                            o_tag_r   <= owner_r;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (O_ready) begin
                        state_r   <= ST_IDLE;
                        o_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    o_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Readies depend only on state and owner registers.
    assign I0_ready = (state_r == ST_ACCUM) && (owner_r == 1'b0);
    assign I1_ready = (state_r == ST_ACCUM) && (owner_r == 1'b1);
    assign O_valid  = o_valid_r;
    assign O_data   = o_data_r;
    assign O_tag    = o_tag_r;

endmodule

// File: doc/xor_fold_scheduler.md
Name: xor_fold_scheduler

Overview:
Shared serial XOR-fold engine arbitrated between two requesters. Each requester streams one frame of LEN words of WIDTH bits over valid/ready. The block grants the single 2-operand XOR accumulator to one requester per frame, using round-robin order. It returns the folded result (word0 ^ word1 ^ ... ^ word[LEN-1]) with a requester tag. It is the time-multiplexed replacement for a fully unrolled XOR fold chain, trading LEN-1 XOR instances for one XOR plus control.

Parameters:
WIDTH, 2, bit width of each data word and of the result
LEN, 8, words per frame; legal range 1..256

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
I0_valid  input  1  requester 0 word valid
I0_data  input  WIDTH  requester 0 word
I0_ready  output  1  requester 0 word accepted this cycle when high with I0_valid
I1_valid  input  1  requester 1 word valid
I1_data  input  WIDTH  requester 1 word
I1_ready  output  1  requester 1 word accepted this cycle when high with I1_valid
O_valid  output  1  folded result valid
O_data  output  WIDTH  folded result
O_tag  output  1  index of requester that produced O_data
O_ready  input  1  downstream accepts result

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous and active-high.
- Reset state:
  - state=IDLE, acc=0, cnt=0, owner=0, last_grant=1 (so requester 0 wins the first tie).
  - Outputs: O_valid=0, O_data=0, O_tag=0, I0_ready=0, I1_ready=0.
- RESET mid-frame or while a result is pending: the partial accumulation and any un-accepted result are discarded; the requester must restart its frame.
- IDLE state:
  - Both readies are 0.
  - If exactly one Ix_valid is high, grant that requester.
  - If both are high, grant the requester != last_grant.
  - On grant: owner<=grantee, last_grant<=grantee, acc<=0, cnt<=0, go to ACCUM.
  - No word is consumed in the grant cycle.
- ACCUM state:
  - The owner's ready is 1; the non-owner's ready is 0.
  - On an owner valid&ready cycle: acc<=acc^data, cnt<=cnt+1.
  - When the accepted word is the LEN-th (cnt==LEN-1 before increment): go to DONE, with O_data taking the final value acc^data.
  - Owner valid low: hold state, no change; gaps are allowed.
  - The non-owner's valid is ignored; its words are not consumed.
- DONE state:
  - Outputs: O_valid=1, O_data=acc, O_tag=owner; both readies are 0.
  - Hold all outputs stable until O_ready=1.
  - On O_valid&O_ready: go to IDLE and clear O_valid the next cycle.
- Latency: O_valid rises the cycle after the last word is accepted.
- Throughput: minimum cycles per frame is LEN+2 (grant, LEN words, result handshake with O_ready tied high).
- Combinational paths: O_data and O_tag are registered. The readies are decoded from the state and owner registers only, with no combinational path from any input.
- Counter width is clog2(LEN) with a minimum of 1; cnt never wraps because the frame ends at LEN-1.
- LEN=1: a single accepted word moves ACCUM directly to DONE with O_data=that word.
- Arbitration is per frame, never per word.
- A requester may hold valid through a DONE/IDLE turnaround; the round-robin rule still applies at the next IDLE.

Test Plan:
- Single frame, WIDTH=2, LEN=8: reset; I0 sends 3,1,2,2,0,1,3,3 back-to-back with O_ready=1 -> I0_ready high for 8 cycles starting the cycle after grant, O_valid=1 one cycle after the last word, O_data=3, O_tag=0; I1_ready stays 0 throughout.
- Round-robin tie: both requesters valid at reset release; I1 frame is 1,2,3,0,1,2,3,0 -> first result tag=0; second result tag=1 with O_data=0. Repeat with both still valid -> third result tag=0.
- Backpressure and gaps: I0 deasserts valid on alternate cycles; O_ready held 0 for 5 cycles after O_valid -> acc unaffected by gap cycles; O_data/O_tag stable while stalled; the block returns to IDLE exactly one cycle after O_ready=1.
- Non-owner isolation: I1 drives valid with data 3 during I0's frame -> I1_ready=0 every cycle; I0 result is unchanged; I1 is granted at the next IDLE.
- Reset mid-operation: RESET pulsed after 4 of 8 I0 words, then I0 resends a full frame of all 2s -> no O_valid from the aborted frame; the next result is O_data=0, O_tag=0.
- LEN=1 build: I1 sends the single word 2 -> O_valid appears 2 cycles after I1_valid rises, with O_data=2 and O_tag=1.
